// File: rtl/pattern_serializer_pkg.sv
// rtl/pattern_serializer_pkg.sv - shared state encoding and sizing helper for the pattern serializer
package pattern_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit counter must be able to hold the value width itself.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/pattern_serializer_strobe.sv
// rtl/pattern_serializer_strobe.sv - free-running bit-period counter with a wrap pulse
module strobe_gen #(
  parameter int strobe_width = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic strobe
);

  logic [strobe_width-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + strobe_width'(1);
    end
  end

  // Natural binary wrap gives period 2^strobe_width; pulse on the last count.
  assign strobe = enable && (count == '1);

endmodule

// File: rtl/pattern_serializer.sv
// rtl/pattern_serializer.sv - captures a parallel pattern on start and shifts it out one bit per strobe
module pattern_serializer
  import pattern_serializer_pkg::*;
#(
  parameter int width        = 10,
  parameter int strobe_width = 1,
  parameter int msb_first    = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [width-1:0] pattern,
  output logic             serial_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

  localparam int             cw       = cnt_width(width);
  localparam logic [cw-1:0]  last_bit = cw'(width - 1);

  state_t           state;
  state_t           state_next;
  logic [width-1:0] shreg;
  logic [cw-1:0]    bit_cnt;
  logic             strobe;
  logic             sending;
  logic             accept;
  logic             send_bit;
  logic             finish;
  logic             out_bit;

  strobe_gen #(.strobe_width(strobe_width)) u_strobe (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (accept),
    .enable  (sending),
    .strobe  (strobe)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_SEND;
      ST_SEND: if (strobe && (bit_cnt == last_bit)) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    sending  = (state == ST_SEND);
    accept   = (state == ST_IDLE) && start;
    send_bit = sending && strobe;
    finish   = (state == ST_DONE);
    out_bit  = (msb_first != 0) ? shreg[width-1] : shreg[0];
  end

  // busy is held one cycle past the DONE state so it drops together with the done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      serial_out <= 1'b0;
      bit_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      bit_valid <= send_bit;
      done      <= finish;
      if (accept) begin
        shreg   <= pattern;
        bit_cnt <= '0;
      end else if (send_bit) begin
        serial_out <= out_bit;
        shreg      <= (msb_first != 0) ? (shreg << 1) : (shreg >> 1);
        bit_cnt    <= bit_cnt + cw'(1);
      end else if (finish) begin
        serial_out <= 1'b0;
      end
      if (accept) begin
        busy <= 1'b1;
      end else if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pattern_serializer.sv
// tb/tb_pattern_serializer.sv - scoreboard bench for the pattern serializer in two configurations
module tb_pattern_serializer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       a_start, b_start;
  logic [9:0] a_pattern, b_pattern;
  logic       a_serial_out, a_bit_valid, a_busy, a_done;
  logic       b_serial_out, b_bit_valid, b_busy, b_done;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic b;
    int   c;
  } exp_t;

  exp_t a_q[$];
  exp_t b_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pattern_serializer #(.width(10), .strobe_width(1), .msb_first(1)) dut_a (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (a_start),
    .pattern    (a_pattern),
    .serial_out (a_serial_out),
    .bit_valid  (a_bit_valid),
    .busy       (a_busy),
    .done       (a_done)
  );

  pattern_serializer #(.width(10), .strobe_width(2), .msb_first(0)) dut_b (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (b_start),
    .pattern    (b_pattern),
    .serial_out (b_serial_out),
    .bit_valid  (b_bit_valid),
    .busy       (b_busy),
    .done       (b_done)
  );

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (a_bit_valid === 1'b1) begin
      checks++;
      if (a_q.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected_bit: bit_valid=1 at cycle %0d, required no pending bit", cyc);
      end else begin
        e = a_q.pop_front();
        if (a_serial_out !== e.b || cyc != e.c) begin
          errors++;
          $display("FAIL a_bit: got bit %b at cycle %0d, required bit %b at cycle %0d", a_serial_out, cyc, e.b, e.c);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (b_bit_valid === 1'b1) begin
      checks++;
      if (b_q.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected_bit: bit_valid=1 at cycle %0d, required no pending bit", cyc);
      end else begin
        e = b_q.pop_front();
        if (b_serial_out !== e.b || cyc != e.c) begin
          errors++;
          $display("FAIL b_bit: got bit %b at cycle %0d, required bit %b at cycle %0d", b_serial_out, cyc, e.b, e.c);
        end
      end
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    for (int k = 0; k < 22; k++) begin
      if (k == 2) reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({a_serial_out, a_bit_valid, a_busy, a_done, b_serial_out, b_bit_valid, b_busy, b_done} !== 8'b0) begin
        errors++;
        $display("FAIL reset_idle: cycle %0d outputs a=%b%b%b%b b=%b%b%b%b, required all 0", k,
                 a_serial_out, a_bit_valid, a_busy, a_done, b_serial_out, b_bit_valid, b_busy, b_done);
      end
    end
  endtask

  task automatic test_msb_basic();
    logic [9:0] pat = 10'b1011001110;
    int e0;
    @(negedge clk);
    a_pattern = pat;
    a_start   = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    e0 = cyc;
    for (int i = 0; i < 10; i++) a_q.push_back('{pat[9-i], e0 + 2*(i+1)});
    for (int k = 0; k <= 24; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (a_busy !== (k <= 21) || a_done !== (k == 21)) begin
        errors++;
        $display("FAIL msb_busy_done: k=%0d busy=%b done=%b, required busy=%b done=%b", k, a_busy, a_done, k <= 21, k == 21);
      end
      if (k == 21) begin
        checks++;
        if (a_serial_out !== 1'b0) begin
          errors++;
          $display("FAIL msb_done_serial: serial_out=%b in done cycle, required 0", a_serial_out);
        end
      end
    end
    checks++;
    if (a_q.size() != 0) begin
      errors++;
      $display("FAIL msb_missing: %0d bits never seen, required 0", a_q.size());
    end
    a_q.delete();
  endtask

  task automatic test_lsb_slow();
    logic [9:0] pat = 10'h0F3;
    int e0;
    @(negedge clk);
    b_pattern = pat;
    b_start   = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    e0 = cyc;
    for (int i = 0; i < 10; i++) b_q.push_back('{pat[i], e0 + 4*(i+1)});
    for (int k = 1; k <= 44; k++) begin
      @(negedge clk);
      checks++;
      if (b_busy !== (k <= 41) || b_done !== (k == 41)) begin
        errors++;
        $display("FAIL lsb_busy_done: k=%0d busy=%b done=%b, required busy=%b done=%b", k, b_busy, b_done, k <= 41, k == 41);
      end
    end
    checks++;
    if (b_q.size() != 0) begin
      errors++;
      $display("FAIL lsb_missing: %0d bits never seen, required 0", b_q.size());
    end
    b_q.delete();
  endtask

  task automatic test_ignored_start();
    logic [9:0] pat = 10'b1100101011;
    int e0;
    @(negedge clk);
    a_pattern = pat;
    a_start   = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    e0 = cyc;
    for (int i = 0; i < 10; i++) a_q.push_back('{pat[9-i], e0 + 2*(i+1)});
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      checks++;
      if (a_busy !== (k <= 21) || a_done !== (k == 21)) begin
        errors++;
        $display("FAIL ignored_busy_done: k=%0d busy=%b done=%b, required busy=%b done=%b", k, a_busy, a_done, k <= 21, k == 21);
      end
      if (k == 5) begin
        a_start   = 1'b1;
        a_pattern = 10'h3FF;
      end
      if (k == 6) a_start = 1'b0;
    end
    checks++;
    if (a_q.size() != 0) begin
      errors++;
      $display("FAIL ignored_missing: %0d bits never seen, required 0", a_q.size());
    end
    a_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [9:0] pat1 = 10'h0F0;
    logic [9:0] pat2 = 10'h2AA;
    int e0;
    int e1;
    @(negedge clk);
    a_pattern = pat1;
    a_start   = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    e0 = cyc;
    e1 = e0 + 22;
    for (int i = 0; i < 10; i++) a_q.push_back('{pat1[9-i], e0 + 2*(i+1)});
    for (int k = 1; k <= 46; k++) begin
      @(negedge clk);
      checks++;
      if (a_busy !== (k <= 43) || a_done !== (k == 21 || k == 43)) begin
        errors++;
        $display("FAIL b2b_busy_done: k=%0d busy=%b done=%b, required busy=%b done=%b", k, a_busy, a_done, k <= 43, k == 21 || k == 43);
      end
      if (k == 20) begin
        a_start   = 1'b1;
        a_pattern = 10'h3FF;
      end
      if (k == 21) begin
        a_pattern = pat2;
        for (int i = 0; i < 10; i++) a_q.push_back('{pat2[9-i], e1 + 2*(i+1)});
      end
      if (k == 22) a_start = 1'b0;
    end
    checks++;
    if (a_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_missing: %0d bits never seen, required 0", a_q.size());
    end
    a_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [9:0] pat = 10'b1011001110;
    int e0;
    @(negedge clk);
    a_pattern = pat;
    a_start   = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    e0 = cyc;
    for (int i = 0; i < 10; i++) a_q.push_back('{pat[9-i], e0 + 2*(i+1)});
    repeat (8) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({a_serial_out, a_bit_valid, a_busy, a_done} !== 4'b0) begin
      errors++;
      $display("FAIL mid_reset_async: outputs %b%b%b%b right after reset, required 0000", a_serial_out, a_bit_valid, a_busy, a_done);
    end
    a_q.delete();
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({a_serial_out, a_bit_valid, a_busy, a_done} !== 4'b0) begin
        errors++;
        $display("FAIL mid_reset_hold: outputs %b%b%b%b during reset, required 0000", a_serial_out, a_bit_valid, a_busy, a_done);
      end
    end
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({a_busy, a_done} !== 2'b0) begin
        errors++;
        $display("FAIL mid_reset_after: busy=%b done=%b after release, required 0 0", a_busy, a_done);
      end
    end
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    e0 = cyc;
    for (int i = 0; i < 10; i++) a_q.push_back('{pat[9-i], e0 + 2*(i+1)});
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      checks++;
      if (a_busy !== (k <= 21) || a_done !== (k == 21)) begin
        errors++;
        $display("FAIL mid_restart_busy_done: k=%0d busy=%b done=%b, required busy=%b done=%b", k, a_busy, a_done, k <= 21, k == 21);
      end
    end
    checks++;
    if (a_q.size() != 0) begin
      errors++;
      $display("FAIL mid_restart_missing: %0d bits never seen, required 0", a_q.size());
    end
    a_q.delete();
  endtask

  initial begin
    reset_n   = 1'b1;
    a_start   = 1'b0;
    b_start   = 1'b0;
    a_pattern = '0;
    b_pattern = '0;
    #1;
    test_reset();
    test_msb_basic();
    test_lsb_slow();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_serializer.md
# pattern_serializer

Serial pattern transmitter for the FSM lab: captures a parallel pattern from the switches on a start request and shifts it out one bit per strobe period, with a per-bit valid pulse. It is the source end of the lab's serial sequence-detector path: its `serial_out`/`bit_valid` pair feeds the detector's shift input in place of the debounced key. It sits inside `top` beside the debouncer and seven-segment driver.

## Interface

Parameters:
- `width`, 10: pattern length in bits; equals the switch bus width.
- `strobe_width`, 1: strobe counter width. Bit period P = 2^strobe_width clock cycles.
- `msb_first`, 1: 1 sends `pattern[width-1]` first; 0 sends `pattern[0]` first.

Ports:
- `clk`  input  1  system clock (50 MHz on DE10-Lite).
- `reset_n`  input  1  one clock; reset is asynchronous and active-low.
- `start`  input  1  single-cycle request from the debounced key, already synchronous to `clk`.
- `pattern`  input  `width`  parallel pattern, sampled only in the cycle `start` is accepted.
- `serial_out`  output  1  current transmitted bit, registered.
- `bit_valid`  output  1  one-cycle pulse marking each new `serial_out` bit, registered.
- `busy`  output  1  high while a transmission is in progress.
- `done`  output  1  one-cycle pulse after the last bit.

## Operation

- States: IDLE, SEND, DONE.
- IDLE: `start`=1 loads `pattern` into the shift register. It also clears the strobe counter and bit counter, then moves to SEND. `start`=0 stays in IDLE.
- SEND: the strobe counter increments every cycle and wraps at P-1 -> 0. Strobe occurs when the counter equals P-1.
  - On each strobe, `serial_out` takes the outgoing bit (MSB or LSB per `msb_first`), `bit_valid` pulses, the register shifts, and the bit counter increments.
  - On the strobe carrying bit `width`-1, the state moves to DONE.
- DONE: `done`=1 for exactly one cycle, `serial_out` is cleared to 0, then the state moves to IDLE.
- `start` is ignored while `busy`=1. There is no queuing.
- `pattern` changes after the load have no effect on the transmission in flight.
- Reset at any time, including mid-transmission, returns to IDLE immediately and abandons the transmission. No `done` pulse is issued.
- Bit counter is sized ceil(log2(`width`+1)). `width`=1 is legal: one bit, then DONE.

## Timing

- Reset values: `serial_out`=0, `bit_valid`=0, `busy`=0, `done`=0, state IDLE, all counters 0.
- Edge numbering: `start` is sampled high at edge E0.
  - `busy`=1 from after E0.
  - Bit i (i = 0..`width`-1) appears on `serial_out` after edge E0+(i+1)·P, with `bit_valid`=1 for that one cycle only.
  - `serial_out` holds bit i until the next strobe.
  - `done`=1 after edge E0+`width`·P+1 for one cycle.
  - `busy`=0 after edge E0+`width`·P+2.
- Total occupancy is `width`·P+2 cycles. A new `start` is accepted no earlier than edge E0+`width`·P+2.
- `start` coinciding with the DONE cycle is dropped.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure

- State encoding (IDLE=2'd0, SEND=2'd1, DONE=2'd2) goes as localparams in a shared include alongside `config.vh`, so the detector lab and the bench use the same encoding.
- One sub-module, `strobe_gen`:
  - parameter `strobe_width`; inputs `clk`, `reset_n`, `clear`, `enable`; output `strobe`.
  - Generates the wrap pulse.
- The top-level block holds the FSM, shift register and bit counter.

## Test plan

- Reset/idle: hold `reset_n`=0 for 2 cycles, then release with `start`=0 for 20 cycles -> all outputs 0 throughout.
- Basic MSB-first: `width`=10, `strobe_width`=1, `pattern`=10'b1011001110, `start` pulse at E0.
  - `bit_valid` pulses at E2, E4, …, E20 with bits 1,0,1,1,0,0,1,1,1,0.
  - `done` after E21; `busy` low after E22.
- LSB-first and slow strobe: `msb_first`=0, `strobe_width`=2, `pattern`=10'h0F3 -> bits 1,1,0,0,1,1,1,1,0,0 at E4, E8, …, E40.
- Ignored start and frozen pattern: pulse `start` again mid-SEND and change `pattern` to 10'h3FF -> no restart, transmitted bits unchanged, exactly one `done`.
- Back-to-back: `start` at E0+22 (first accepted slot) with 10'h2AA -> second transmission begins cleanly with alternating 1,0 bits. A `start` at E0+21 (DONE cycle) is dropped.
- Reset mid-operation: assert `reset_n`=0 after the 4th `bit_valid` -> outputs 0 immediately (asynchronous), no `done`, a fresh `start` after release transmits the full pattern from bit 0.
